aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer that drives the iterative AES-128 key scheduler (control_signal / round_number) and serves
//  round keys to the decryption datapath. On start: loads cipher key, runs forward expansion to round
//  key 10, then streams keys 10..0 in descending order via valid/ready, using reverse expansion per step.
//  Sits between the decryption round controller (consumer) and the key scheduler (register + fwd/rev calc).
// PARAMETERS
//  NUM_ROUNDS  10   rounds of expansion; last key index served first (AES-128 only)
//  KEY_W       128  key / round-key width
// PORTS
//  clk                 in   1      single clock, rising edge
//  rst                 in   1      synchronous, active-high reset
//  start               in   1      begin new key session; sampled only when busy=0
//  key_in              in   KEY_W  cipher key, captured on accepted start
//  busy                out  1      session in progress (load, expand or serve)
//  ks_control_signal   out  2      to scheduler: 00 hold, 01 load, 10 forward, 11 reverse
//  ks_round_number     out  4      to scheduler: Rcon index for forward/reverse step
//  ks_load_key         out  KEY_W  to scheduler load_key_in; registered copy of key_in
//  ks_round_key        in   KEY_W  from scheduler: current registered round key
//  rk_valid            out  1      rk_data holds round key rk_index
//  rk_ready            in   1      consumer accepts key this cycle
//  rk_data             out  KEY_W  = ks_round_key (pass-through)
//  rk_index            out  4      round index of rk_data, 10 down to 0
//  rk_last             out  1      rk_valid & rk_index==0
// BEHAVIOUR
//  - Reset (sync): state IDLE; busy=0, rk_valid=0, rk_index=0, ks_control_signal=00, ks_round_number=0,
//    ks_load_key=0. rst mid-session aborts immediately; scheduler contents are don't-care afterwards.
//  - States: IDLE -> LOAD -> EXPAND -> SERVE -> IDLE.
//  - IDLE: control=00. start=1 at edge T0: capture key_in into ks_load_key, go LOAD, busy=1 from T0+1.
//  - LOAD (1 cycle): control=01; scheduler holds cipher key (round key 0) after this edge.
//  - EXPAND: 4-bit counter r=1..NUM_ROUNDS, one per cycle; control=10, ks_round_number=r. After r=10
//    edge scheduler holds RK10; go SERVE with rk_index=10. rk_valid first high 12 cycles after start edge.
//  - SERVE: rk_valid=1. No handshake: control=00 (key held stable), rk_index held.
//    Handshake (rk_valid&rk_ready) with rk_index>0: same cycle control=11, ks_round_number=rk_index
//    (RK[i] -> RK[i-1] uses Rcon[i]); rk_index decrements; rk_valid stays 1 -> one key per cycle max.
//    Handshake with rk_index==0: go IDLE, control=00, rk_valid=0 and busy=0 next cycle.
//  - ks_control_signal / ks_round_number are combinational from state, counter and handshake;
//    all other outputs registered. rk_data combinational pass-through of ks_round_key.
//  - start while busy=1 ignored (key_in not captured). start in the same cycle as final handshake ignored;
//    new session requires start while busy=0.
//  - rk_ready ignored outside SERVE. Counter never wraps: r stops at 10, rk_index stops at 0.
//  - Backpressure: rk_ready low for any number of cycles holds rk_data/rk_index unchanged.
// TESTING
//  1. key_in=000102030405060708090a0b0c0d0e0f, start, rk_ready=1 -> rk_valid at +12 cycles,
//     rk_index=10, rk_data=13111d7fe3944a17f307a78b4d2b30c5; 11 consecutive keys ending key_in, rk_last on last.
//  2. key_in=2b7e151628aed2a6abf7158809cf4f3c -> RK10=d014f9a8c9ee2589e13f0cc8b6630ca6,
//     RK9=ac7766f319fadc2128d12941575c006e, RK1=a0fafe1788542cb123a339392a6c7605, RK0=key_in.
//  3. Random rk_ready stalls (e.g. low 5 cycles at index 7) -> data/index stable, control=00 while stalled,
//     sequence identical to case 2.
//  4. start pulsed with different key during EXPAND and SERVE -> ignored; served keys match first key.
//  5. rst asserted in EXPAND (r=4) and in SERVE (index=6) -> next cycle busy=0, rk_valid=0, control=00;
//     fresh start then yields correct full sequence.
//  6. Back-to-back sessions: start one cycle after busy falls -> second key sequence correct, no stale index.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Sequencer for an iterative AES-128 key scheduler that feeds round keys to a
// decryption datapath in descending order (RK10 first, RK0 last).
//
// A session loads the cipher key into the scheduler, walks it forward to RK10,
// then serves keys 10..0 over a valid/ready handshake. The scheduler steps
// backwards one round per accepted key.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, key_in       begin a session; key_in captured when start is accepted
//   busy                session in progress (load, expand or serve)
//   ks_control_signal   scheduler op: 00 hold, 01 load, 10 forward, 11 reverse
//   ks_round_number     Rcon index for the forward/reverse step
//   ks_load_key         registered copy of the captured cipher key
//   ks_round_key        current round key held by the scheduler
//   rk_valid/rk_ready   round-key handshake towards the consumer
//   rk_data             pass-through of ks_round_key
//   rk_index            round index of rk_data (10 down to 0)
//   rk_last             rk_valid and rk_index == 0
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic [1:0]       ks_control_signal,
    output logic [3:0]       ks_round_number,
    output logic [KEY_W-1:0] ks_load_key,
    input  logic [KEY_W-1:0] ks_round_key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [3:0]       rk_index,
    output logic             rk_last
);

    localparam logic [3:0] LP_LAST = 4'(NUM_ROUNDS);

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_LOAD = 2'b01;
    localparam logic [1:0] CTRL_FWD  = 2'b10;
    localparam logic [1:0] CTRL_REV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_SERVE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_round;
    logic               r_busy;
    logic               r_rk_valid;
    logic [3:0]         r_rk_index;
    logic               r_rk_last;
    logic [KEY_W-1:0]   r_load_key;

    state_t             w_state_nxt;
    logic [3:0]         w_round_nxt;
    logic               w_busy_nxt;
    logic               w_valid_nxt;
    logic [3:0]         w_index_nxt;
    logic               w_last_nxt;
    logic [KEY_W-1:0]   w_load_key_nxt;
    logic [1:0]         w_ctrl;
    logic [3:0]         w_rnum;
    logic               w_hs;

    assign w_hs = r_rk_valid & rk_ready;

    // State, counter and registered outputs; reset aborts any session at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_round    <= 4'd0;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_index <= 4'd0;
            r_rk_last  <= 1'b0;
            r_load_key <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_round    <= w_round_nxt;
            r_busy     <= w_busy_nxt;
            r_rk_valid <= w_valid_nxt;
            r_rk_index <= w_index_nxt;
            r_rk_last  <= w_last_nxt;
            r_load_key <= w_load_key_nxt;
        end
    end

    // Next-state logic and the combinational scheduler command.
    always_comb begin
        w_state_nxt    = r_state;
        w_round_nxt    = r_round;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = r_rk_valid;
        w_index_nxt    = r_rk_index;
        w_load_key_nxt = r_load_key;
        w_ctrl         = CTRL_HOLD;
        w_rnum         = 4'd0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_key_nxt = key_in;
                    w_state_nxt    = ST_LOAD;
                    w_busy_nxt     = 1'b1;
                    w_round_nxt    = 4'd0;
                    w_index_nxt    = 4'd0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_ctrl      = CTRL_LOAD;
                w_state_nxt = ST_EXPAND;
                w_round_nxt = 4'd1;
            end
            ST_EXPAND: begin
                w_ctrl = CTRL_FWD;
                w_rnum = r_round;
                // The step with r == NUM_ROUNDS leaves RK10 in the scheduler.
                if (r_round >= LP_LAST) begin
                    w_state_nxt = ST_SERVE;
                    w_valid_nxt = 1'b1;
                    w_index_nxt = LP_LAST;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            ST_SERVE: begin
                if (w_hs) begin
                    if (r_rk_index != 4'd0) begin
                        // RK[i] -> RK[i-1] undoes the forward step that used Rcon[i].
                        w_ctrl      = CTRL_REV;
                        w_rnum      = r_rk_index;
                        w_index_nxt = r_rk_index - 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_ctrl = CTRL_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                w_index_nxt = 4'd0;
                w_round_nxt = 4'd0;
            end
        endcase

        w_last_nxt = w_valid_nxt & (w_index_nxt == 4'd0);
    end

    assign busy              = r_busy;
    assign ks_control_signal = w_ctrl;
    assign ks_round_number   = w_rnum;
    assign ks_load_key       = r_load_key;
    assign rk_valid          = r_rk_valid;
    assign rk_data           = ks_round_key;
    assign rk_index          = r_rk_index;
    assign rk_last           = r_rk_last;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: includes a behavioural AES-128 key scheduler
// (load / forward / reverse) driven by the controller's command outputs.
// Expected keys come from FIPS-197 constants and a forward-only expansion.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic [1:0]   ks_control_signal;
    logic [3:0]   ks_round_number;
    logic [127:0] ks_load_key;
    logic [127:0] ks_rk;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_data [0:10];
    int           got_idx [0:10];
    logic         got_last [0:10];
    logic [1:0]   got_ctrl [0:10];
    logic [3:0]   got_rnum [0:10];
    int           n_got;
    int           stall_bad;
    int           stall_seen;
    bit           timed_out;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_sched_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .key_in            (key_in),
        .busy              (busy),
        .ks_control_signal (ks_control_signal),
        .ks_round_number   (ks_round_number),
        .ks_load_key       (ks_load_key),
        .ks_round_key      (ks_rk),
        .rk_valid          (rk_valid),
        .rk_ready          (rk_ready),
        .rk_data           (rk_data),
        .rk_index          (rk_index),
        .rk_last           (rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r = {w[23:0], w[31:24]};
        return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] rev(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    // External key scheduler model reacting to the controller's commands.
    always_ff @(posedge clk) begin
        case (ks_control_signal)
            2'b01:   ks_rk <= ks_load_key;
            2'b10:   ks_rk <= fwd(ks_rk, rcon(ks_round_number));
            2'b11:   ks_rk <= rev(ks_rk, rcon(ks_round_number));
            default: ks_rk <= ks_rk;
        endcase
    end

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        exp_rk[0] = k;
        for (int i = 1; i <= 10; i++) exp_rk[i] = fwd(exp_rk[i-1], rcon(4'(i)));
    endtask

    // Presents start for exactly one rising edge; returns at the following negedge.
    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
    endtask

    // e counts rising edges including the one that sampled start.
    task automatic wait_valid(output int e);
        e = 1;
        while (!rk_valid && e < 40) begin
            @(negedge clk);
            e++;
        end
    endtask

    // Consumes up to 11 keys; optional stall at one index and optional start pulse.
    task automatic collect(input int stall_at, input int stall_len, input int pulse_at,
                           input logic [127:0] pulse_key);
        int cyc = 0;
        int left = stall_len;
        logic [127:0] ref_d = '0;
        n_got = 0; stall_bad = 0; stall_seen = 0;
        while (n_got < 11 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rk_valid && int'(rk_index) == stall_at && left > 0) begin
                rk_ready = 1'b0;
                #1;
                if (left == stall_len) ref_d = rk_data;
                else if (rk_data !== ref_d) stall_bad++;
                if (ks_control_signal !== 2'b00 || int'(rk_index) != stall_at) stall_bad++;
                left--;
                stall_seen++;
            end else begin
                rk_ready = 1'b1;
                if (rk_valid && int'(rk_index) == pulse_at) begin
                    start  = 1'b1;
                    key_in = pulse_key;
                end
                #1;
                if (rk_valid) begin
                    got_data[n_got] = rk_data;
                    got_idx[n_got]  = int'(rk_index);
                    got_last[n_got] = rk_last;
                    got_ctrl[n_got] = ks_control_signal;
                    got_rnum[n_got] = ks_round_number;
                    n_got++;
                end
            end
        end
        timed_out = (n_got < 11);
    endtask

    task automatic check_seq(input string tag);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s_timeout: got %0d keys want 11", tag, n_got);
        end
        for (int i = 0; i < 11; i++) begin
            total++;
            if (got_data[i] !== exp_rk[10-i] || got_idx[i] != 10 - i || got_last[i] !== (i == 10)) begin
                bad++;
                $display("FAIL %s_key%0d: got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
                         tag, i, got_idx[i], got_last[i], got_data[i], 10 - i, (i == 10), exp_rk[10-i]);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || ks_control_signal !== 2'b00 || rk_last !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b valid=%b ctrl=%b last=%b want 0 0 00 0",
                     tag, busy, rk_valid, ks_control_signal, rk_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; key_in = KEY2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_index !== 4'd0 || ks_control_signal !== 2'b00 ||
            ks_round_number !== 4'd0 || ks_load_key !== 128'd0 || rk_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b valid=%b idx=%0d ctrl=%b rnum=%0d lk=%h want zeros",
                     busy, rk_valid, rk_index, ks_control_signal, ks_round_number, ks_load_key);
        end
        rst = 1'b0; start = 1'b0; key_in = '0;
    endtask

    task automatic test_vector1();
        int e;
        expand(KEY1);
        do_start(KEY1);
        total++;
        if (busy !== 1'b1 || ks_load_key !== KEY1 || ks_control_signal !== 2'b01) begin
            bad++;
            $display("FAIL v1_accept: got busy=%b ctrl=%b lk=%h want 1 01 %h", busy, ks_control_signal, ks_load_key, KEY1);
        end
        wait_valid(e);
        total++;
        if (e != 12) begin
            bad++;
            $display("FAIL v1_latency: got %0d want 12", e);
        end
        total++;
        if (rk_index !== 4'd10 || rk_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5 || rk_last !== 1'b0) begin
            bad++;
            $display("FAIL v1_rk10: got idx=%0d data=%h last=%b want 10 13111d7fe3944a17f307a78b4d2b30c5 0",
                     rk_index, rk_data, rk_last);
        end
        collect(-1, 0, -1, 128'd0);
        check_seq("v1");
        for (int i = 0; i < 11; i++) begin
            total++;
            if (got_ctrl[i] !== ((i < 10) ? 2'b11 : 2'b00) || got_rnum[i] !== ((i < 10) ? 4'(10 - i) : 4'd0)) begin
                bad++;
                $display("FAIL v1_cmd%0d: got ctrl=%b rnum=%0d want ctrl=%b rnum=%0d",
                         i, got_ctrl[i], got_rnum[i], (i < 10) ? 2'b11 : 2'b00, (i < 10) ? 10 - i : 0);
            end
        end
        total++;
        if (got_data[10] !== KEY1) begin
            bad++;
            $display("FAIL v1_rk0: got %h want %h", got_data[10], KEY1);
        end
        @(negedge clk);
        rk_ready = 1'b0; start = 1'b0;
        #1;
        check_idle("v1_end");
    endtask

    task automatic test_vector2();
        int e;
        expand(KEY2);
        do_start(KEY2);
        wait_valid(e);
        collect(-1, 0, -1, 128'd0);
        total++;
        if (got_data[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || got_data[1] !== 128'hac7766f319fadc2128d12941575c006e ||
            got_data[9] !== 128'ha0fafe1788542cb123a339392a6c7605 || got_data[10] !== KEY2) begin
            bad++;
            $display("FAIL v2_fips: got rk10=%h rk9=%h rk1=%h rk0=%h want d014f9a8c9ee2589e13f0cc8b6630ca6 ac7766f319fadc2128d12941575c006e a0fafe1788542cb123a339392a6c7605 %h",
                     got_data[0], got_data[1], got_data[9], got_data[10], KEY2);
        end
        check_seq("v2");
        @(negedge clk);
        rk_ready = 1'b0;
        #1;
        check_idle("v2_end");
    endtask

    task automatic test_stall();
        int e;
        expand(KEY2);
        do_start(KEY2);
        wait_valid(e);
        collect(7, 5, -1, 128'd0);
        total++;
        if (stall_bad != 0 || stall_seen != 5) begin
            bad++;
            $display("FAIL stall_hold: got errors=%0d cycles=%0d want 0 5", stall_bad, stall_seen);
        end
        check_seq("stall");
        @(negedge clk);
        rk_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int e;
        expand(KEY1);
        do_start(KEY1);
        repeat (3) @(negedge clk);
        start = 1'b1; key_in = KEY2;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (ks_load_key !== KEY1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ign_expand: got lk=%h busy=%b want %h 1", ks_load_key, busy, KEY1);
        end
        wait_valid(e);
        collect(-1, 0, 5, KEY2);
        check_seq("ign");
        @(negedge clk);
        rk_ready = 1'b0; start = 1'b0;
        total++;
        if (ks_load_key !== KEY1) begin
            bad++;
            $display("FAIL ign_serve: got lk=%h want %h", ks_load_key, KEY1);
        end
    endtask

    task automatic test_abort();
        int e;
        int cnt = 0;
        do_start(KEY1);
        while (!(ks_control_signal === 2'b10 && ks_round_number === 4'd4) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (cnt >= 20) begin
            bad++;
            $display("FAIL abort_find_r4: got timeout want r=4 in expand");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort_exp");
        do_start(KEY1);
        wait_valid(e);
        cnt = 0;
        while (rk_index !== 4'd6 && cnt < 30) begin
            rk_ready = 1'b1;
            @(negedge clk);
            cnt++;
        end
        rk_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort_srv");
        total++;
        if (rk_index !== 4'd0) begin
            bad++;
            $display("FAIL abort_index: got %0d want 0", rk_index);
        end
        expand(KEY2);
        do_start(KEY2);
        wait_valid(e);
        collect(-1, 0, -1, 128'd0);
        check_seq("abort_fresh");
        @(negedge clk);
        rk_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e;
        expand(KEY1);
        do_start(KEY1);
        wait_valid(e);
        collect(-1, 0, 0, KEY2);
        check_seq("b2b_first");
        @(negedge clk);
        rk_ready = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || ks_load_key !== KEY1) begin
            bad++;
            $display("FAIL b2b_final_start: got busy=%b lk=%h want 0 %h", busy, ks_load_key, KEY1);
        end
        expand(KEY2);
        do_start(KEY2);
        wait_valid(e);
        total++;
        if (e != 12 || rk_index !== 4'd10) begin
            bad++;
            $display("FAIL b2b_second_head: got latency=%0d idx=%0d want 12 10", e, rk_index);
        end
        collect(-1, 0, -1, 128'd0);
        check_seq("b2b_second");
        @(negedge clk);
        rk_ready = 1'b0;
        #1;
        check_idle("b2b_end");
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vector1();
        test_vector2();
        test_stall();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
